vector_lsu: RTL and testbench

VECTOR_LSU -- requirements
Module: vector_lsu

---
 rtl/cvp14_pkg.sv | 22 ++
 rtl/vector_lsu.sv | 158 +++++++++++++++
 tb/tb_vector_lsu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cvp14_pkg.sv
// cvp14_pkg -- shared definitions for the CVP14 vector load/store unit.
//
// Contents:
//   lsu_state_t : FSM state encoding of vector_lsu
//   OP_VLD/OP_VST : values of req_store selecting vector load / vector store
//   IDX_W       : width of the element counter
package cvp14_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LOAD_TAIL = 3'd2,
        ST_STORE     = 3'd3,
        ST_DONE      = 3'd4
    } lsu_state_t;

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;

    localparam int IDX_W = 5;

endpackage

// File: rtl/vector_lsu.sv
// vector_lsu -- sequences a whole-vector load (VLD) or store (VST) onto a
// single-word memory port, one element per cycle.
//
// Ports:
//   Clk1        in   system clock, all state changes on posedge
//   Reset       in   synchronous, active-high reset
//   req_valid   in   request present from execute stage
//   req_ready   out  high only in IDLE; request accepted when valid & ready
//   req_store   in   OP_VST = store, OP_VLD = load
//   req_base    in   word address of element 0
//   req_data    in   store vector, element i in bits [ELEM_W*i +: ELEM_W]
//   done_valid  out  one-cycle completion pulse
//   done_data   out  last assembled load vector (held until next load ends)
//   Addr        out  memory word address
//   RD          out  memory read strobe
//   WR          out  memory write strobe
//   dataOut     out  memory write data
//   DataIn      in   memory read data, valid the cycle after the RD cycle
//
// Request handshake: a request transfers on a Clk1 posedge where req_valid
// and req_ready are both 1; req_store/req_base/req_data are captured at that
// edge. The requester holds req_valid until it sees req_ready; while busy
// req_valid is ignored.
//
// All outputs are registers loaded with the value belonging to the state
// being entered, so they never depend combinationally on DataIn.
module vector_lsu
    import cvp14_pkg::*;
#(
    parameter int NUM_ELEM = 16,
    parameter int ELEM_W   = 16
) (
    input  logic                       Clk1,
    input  logic                       Reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_store,
    input  logic [15:0]                req_base,
    input  logic [NUM_ELEM*ELEM_W-1:0] req_data,
    output logic                       done_valid,
    output logic [NUM_ELEM*ELEM_W-1:0] done_data,
    output logic [15:0]                Addr,
    output logic                       RD,
    output logic                       WR,
    output logic [ELEM_W-1:0]          dataOut,
    input  logic [ELEM_W-1:0]          DataIn
);

    localparam int VEC_W = NUM_ELEM * ELEM_W;
    // The last element bypasses the assembly buffer straight into done_data.
    localparam int BUF_W = VEC_W - ELEM_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    lsu_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        base_q;
    logic [VEC_W-1:0]   st_data_q;
    logic [BUF_W-1:0]   ld_buf;

    logic [IDX_W-1:0]   idx_p1;
    logic [IDX_W-1:0]   idx_m1;

    assign idx_p1 = idx + 1'b1;
    assign idx_m1 = idx - 1'b1;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            base_q     <= '0;
            st_data_q  <= '0;
            ld_buf     <= '0;
            req_ready  <= 1'b1;
            done_valid <= 1'b0;
            done_data  <= '0;
            Addr       <= '0;
            RD         <= 1'b0;
            WR         <= 1'b0;
            dataOut    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_valid <= 1'b0;
                    // req_ready is always 1 here, so valid alone accepts.
                    if (req_valid) begin
                        base_q    <= req_base;
                        st_data_q <= req_data;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        Addr      <= req_base;
                        if (req_store == OP_VST) begin
                            state   <= ST_STORE;
                            WR      <= 1'b1;
                            dataOut <= req_data[ELEM_W-1:0];
                        end else begin
                            state <= ST_LOAD;
                            RD    <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    // DataIn now carries the word read for element idx-1.
                    if (idx != '0)
                        ld_buf[idx_m1*ELEM_W +: ELEM_W] <= DataIn;
                    if (idx == LAST_IDX) begin
                        state <= ST_LOAD_TAIL;
                        idx   <= '0;
                        RD    <= 1'b0;
                        Addr  <= '0;
                    end else begin
                        idx  <= idx_p1;
                        Addr <= base_q + 16'(idx_p1);
                    end
                end

                ST_LOAD_TAIL: begin
                    done_data  <= {DataIn, ld_buf};
                    done_valid <= 1'b1;
                    state      <= ST_DONE;
                end

                ST_STORE: begin
                    if (idx == LAST_IDX) begin
                        state      <= ST_DONE;
                        idx        <= '0;
                        done_valid <= 1'b1;
                        WR         <= 1'b0;
                        Addr       <= '0;
                        dataOut    <= '0;
                    end else begin
                        idx     <= idx_p1;
                        Addr    <= base_q + 16'(idx_p1);
                        dataOut <= st_data_q[idx_p1*ELEM_W +: ELEM_W];
                    end
                end

                ST_DONE: begin
                    done_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    state      <= ST_IDLE;
                    idx        <= '0;
                    req_ready  <= 1'b1;
                    done_valid <= 1'b0;
                    Addr       <= '0;
                    RD         <= 1'b0;
                    WR         <= 1'b0;
                    dataOut    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu -- self-checking bench for vector_lsu with a word memory
// model attached to the memory port and a reference model of each transfer.
module tb_vector_lsu;
    import cvp14_pkg::*;

    localparam int NE = 16;
    localparam int EW = 16;
    localparam int DW = NE * EW;

    // ---------------- clock / DUT ----------------
    logic          Clk1;
    logic          Reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [15:0]   req_base;
    logic [DW-1:0] req_data;
    logic          done_valid;
    logic [DW-1:0] done_data;
    logic [15:0]   Addr;
    logic          RD;
    logic          WR;
    logic [EW-1:0] dataOut;
    logic [EW-1:0] DataIn;

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    vector_lsu #(.NUM_ELEM(NE), .ELEM_W(EW)) dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_base  (req_base),
        .req_data  (req_data),
        .done_valid(done_valid),
        .done_data (done_data),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .dataOut   (dataOut),
        .DataIn    (DataIn)
    );

    // ---------------- scoreboard state ----------------
    int            n_assert = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    logic [DW-1:0] last_load;
    logic [15:0]   rd_addr_q[$];
    logic [15:0]   wr_addr_q[$];
    logic [15:0]   wr_data_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Single process owns the array: random fill, known pattern, then
    // a synchronous port with one-cycle read latency.
    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < NE; i++) mem[16'h0100 + i] = 16'h1000 + 16'(i);
        DataIn = '0;
        forever begin
            @(posedge Clk1);
            if (RD) DataIn <= mem[Addr];
            else    DataIn <= 16'($urandom);
            if (WR) mem[Addr] <= dataOut;
        end
    end

    // ---------------- bus monitor ----------------
    always @(negedge Clk1) begin
        if (!Reset) begin
            chk("rd_wr_excl", DW'(RD & WR), '0);
            if (RD) rd_addr_q.push_back(Addr);
            if (WR) begin
                wr_addr_q.push_back(Addr);
                wr_data_q.push_back(dataOut);
            end
            if (!RD && !WR) begin
                chk("idle_addr", DW'(Addr), '0);
                chk("idle_dout", DW'(dataOut), '0);
            end
            if (done_valid) done_cnt++;
        end
    end

    // ---------------- driver + reference ----------------
    // Issue one request from an IDLE cycle and check the full transfer.
    task automatic run_req(input logic st, input logic [15:0] base,
                           input logic [DW-1:0] data, input bit hold_valid,
                           input string tag);
        logic [DW-1:0] exp_vec;
        int waitc;
        int lat;
        bit got;
        exp_vec = '0;
        if (st == OP_VLD)
            for (int i = 0; i < NE; i++) exp_vec[i*EW +: EW] = mem[16'(base + 16'(i))];
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();

        req_valid = 1'b1;
        req_store = st;
        req_base  = base;
        req_data  = data;
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(posedge Clk1); #1;
            waitc++;
        end
        chk({tag, "_accept_wait"}, DW'(waitc), '0);
        if (!req_ready) return;

        @(posedge Clk1); #1;   // accept edge
        exp_done++;
        if (!hold_valid) req_valid = 1'b0;
        // Inputs change after accept; the DUT must use captured copies.
        req_base  = 16'($urandom);
        req_data  = {8{$urandom}};
        req_store = 1'($urandom);

        lat = 0;
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done_valid) begin
                lat = c;
                got = 1;
                break;
            end
            chk({tag, "_busy_ready"}, DW'(req_ready), '0);
            @(posedge Clk1); #1;
        end
        chk({tag, "_latency"}, DW'(lat), (st == OP_VST) ? DW'(NE + 1) : DW'(NE + 2));
        if (!got) return;

        if (st == OP_VLD) begin
            chk({tag, "_done_data"}, done_data, exp_vec);
            last_load = exp_vec;
            chk({tag, "_rd_count"}, DW'(rd_addr_q.size()), DW'(NE));
            chk({tag, "_wr_count"}, DW'(wr_addr_q.size()), '0);
            for (int i = 0; i < NE; i++)
                if (i < rd_addr_q.size())
                    chk({tag, "_rd_addr"}, DW'(rd_addr_q[i]), DW'(16'(base + 16'(i))));
        end else begin
            chk({tag, "_done_data_held"}, done_data, last_load);
            chk({tag, "_wr_count"}, DW'(wr_addr_q.size()), DW'(NE));
            chk({tag, "_rd_count"}, DW'(rd_addr_q.size()), '0);
            for (int i = 0; i < NE; i++)
                if (i < wr_addr_q.size()) begin
                    chk({tag, "_wr_addr"}, DW'(wr_addr_q[i]), DW'(16'(base + 16'(i))));
                    chk({tag, "_wr_data"}, DW'(wr_data_q[i]), DW'(data[i*EW +: EW]));
                end
        end
        @(posedge Clk1); #1;
        chk({tag, "_pulse_end"}, DW'(done_valid), '0);
        chk({tag, "_idle_ready"}, DW'(req_ready), DW'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] vec;
        int dc;
        Reset     = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_base  = '0;
        req_data  = '0;
        last_load = '0;
        repeat (3) @(posedge Clk1);
        #1;
        chk("rst_ready", DW'(req_ready), DW'(1));
        chk("rst_done", DW'(done_valid), '0);
        chk("rst_rdwr", DW'({RD, WR}), '0);
        chk("rst_addr", DW'(Addr), '0);
        chk("rst_dout", DW'(dataOut), '0);
        chk("rst_ddata", done_data, '0);
        Reset = 1'b0;
        @(posedge Clk1); #1;

        // Known-pattern load
        run_req(OP_VLD, 16'h0100, '0, 0, "load100");
        for (int i = 0; i < NE; i++) vec[i*EW +: EW] = 16'h1000 + 16'(i);
        chk("load100_pattern", done_data, vec);

        // Known-pattern store
        for (int i = 0; i < NE; i++) vec[i*EW +: EW] = 16'hA500 + 16'(i);
        run_req(OP_VST, 16'h0200, vec, 0, "store200");

        // Address wrap
        run_req(OP_VLD, 16'hFFF8, '0, 0, "wrap");

        // Reset mid-load at idx=5
        req_valid = 1'b1;
        req_store = OP_VLD;
        req_base  = 16'h0300;
        @(posedge Clk1); #1;
        req_valid = 1'b0;
        repeat (5) begin
            @(posedge Clk1); #1;
        end
        chk("abort_pre_rd", DW'(RD), DW'(1));
        chk("abort_pre_addr", DW'(Addr), DW'(16'h0305));
        Reset = 1'b1;
        @(posedge Clk1); #1;
        chk("abort_rd", DW'(RD), '0);
        chk("abort_ready", DW'(req_ready), DW'(1));
        chk("abort_done", DW'(done_valid), '0);
        chk("abort_addr", DW'(Addr), '0);
        chk("abort_ddata", done_data, '0);
        last_load = '0;
        Reset = 1'b0;
        rd_addr_q.delete();
        dc = done_cnt;
        repeat (20) begin
            @(posedge Clk1); #1;
        end
        chk("abort_no_rd", DW'(rd_addr_q.size()), '0);
        chk("abort_no_done", DW'(done_cnt), DW'(dc));
        run_req(OP_VLD, 16'h0300, '0, 0, "after_abort");

        // req_valid held high, alternating load/store
        run_req(OP_VLD, 16'h0400, '0, 1, "busy_ld0");
        run_req(OP_VST, 16'h0400, {8{$urandom}}, 1, "busy_st0");
        run_req(OP_VLD, 16'h0400, '0, 1, "busy_ld1");
        run_req(OP_VST, 16'h0500, {8{$urandom}}, 0, "busy_st1");

        // Random transfers
        for (int k = 0; k < 8; k++)
            run_req(1'($urandom), 16'($urandom), {8{$urandom}}, 0, "rand");

        repeat (3) @(posedge Clk1);
        #1;
        chk("done_pulse_count", DW'(done_cnt), DW'(exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
